// File: rtl/dac_spi_output.sv
// dac_spi_output: buffers signed 16-bit synth samples in a small FIFO and streams each
// one to a DAC as an offset-binary word over a mode-0 SPI link, MSB first.
//
// Ports:
//   i_Clock          sole clock, rising edge
//   i_Reset          asynchronous active-low reset
//   i_SampleReady    one-cycle strobe qualifying i_Sample
//   i_Sample[15:0]   signed two's-complement sample
//   i_ClearOverflow  clears the sticky overflow flag
//   o_Overflow       sticky: a sample was dropped because the FIFO was full
//   o_Level          FIFO occupancy
//   o_SPI_CS_n       DAC chip select, active-low
//   o_SPI_SCLK       SPI clock, idle low
//   o_SPI_MOSI       serial data, MSB first
module dac_spi_output #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_SampleReady,
    input  logic [15:0]                   i_Sample,
    input  logic                          i_ClearOverflow,
    output logic                          o_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_Level,
    output logic                          o_SPI_CS_n,
    output logic                          o_SPI_SCLK,
    output logic                          o_SPI_MOSI
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   LevelFull = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   LevelOne  = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne    = AW'(1);
    localparam logic [8:0]    PhaseLast = 9'(CLK_DIV - 1);
    localparam logic [8:0]    GapLast   = 9'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

    state_e        state_q;
    logic [8:0]    div_cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [15:0]   shreg_q;
    logic          cs_n_q, sclk_q, mosi_q;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q;

    logic          full, pop, push, drop;
    logic [15:0]   head_word;

    assign full = (level_q == LevelFull);
    assign pop  = (state_q == StLoad);
    // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted.
    assign push = i_SampleReady && (!full || pop);
    assign drop = i_SampleReady && full && !pop;

    // Offset binary: flip the sign bit.
    assign head_word = mem_q[rd_ptr_q] ^ 16'h8000;

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LevelOne;
            2'b01:   level_d = level_q - LevelOne;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_Sample;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            level_q <= level_d;
            // Set wins over clear.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (i_ClearOverflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Outputs are registered alongside the state, so each output value belongs to the
    // state it is registered with; the shift register is loaded on entry to LOAD so that
    // MOSI already carries bit 15 during LOAD.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cs_n_q <= 1'b1;
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                    if (level_q != '0) begin
                        state_q   <= StLoad;
                        cs_n_q    <= 1'b0;
                        shreg_q   <= head_word;
                        mosi_q    <= head_word[15];
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                StLoad: begin
                    state_q <= StShift;
                end
                StShift: begin
                    if (div_cnt_q == PhaseLast) begin
                        div_cnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit.
                            sclk_q    <= 1'b0;
                            shreg_q   <= {shreg_q[14:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd15) begin
                                state_q <= StGap;
                                cs_n_q  <= 1'b1;
                                mosi_q  <= 1'b0;
                            end else begin
                                mosi_q <= shreg_q[14];
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 9'd1;
                    end
                end
                StGap: begin
                    if (div_cnt_q == GapLast) begin
                        div_cnt_q <= '0;
                        if (level_q != '0) begin
                            state_q   <= StLoad;
                            cs_n_q    <= 1'b0;
                            shreg_q   <= head_word;
                            mosi_q    <= head_word[15];
                            bit_cnt_q <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 9'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_Overflow = overflow_q;
    assign o_Level    = level_q;
    assign o_SPI_CS_n = cs_n_q;
    assign o_SPI_SCLK = sclk_q;
    assign o_SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_dac_spi_output.sv
// Directed self-checking bench for dac_spi_output. dut_a uses default parameters,
// dut_b uses CLK_DIV=1. A per-DUT monitor records each SPI frame (word shifted in on
// SCLK rises, chip-select low length, rise count) and the CS-high gap before it.
module tb_dac_spi_output;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        ready_a = 1'b0, clr_a = 1'b0;
    logic [15:0] samp_a = '0;
    logic        ovf_a, cs_a, sclk_a, mosi_a;
    logic [2:0]  lv_a;

    logic        ready_b = 1'b0;
    logic [15:0] samp_b = '0;
    logic        ovf_b, cs_b, sclk_b, mosi_b;
    logic [2:0]  lv_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_spi_output dut_a (
        .i_Clock(clk), .i_Reset(rst_n), .i_SampleReady(ready_a), .i_Sample(samp_a),
        .i_ClearOverflow(clr_a), .o_Overflow(ovf_a), .o_Level(lv_a),
        .o_SPI_CS_n(cs_a), .o_SPI_SCLK(sclk_a), .o_SPI_MOSI(mosi_a)
    );

    dac_spi_output #(.CLK_DIV(1), .FIFO_DEPTH(4)) dut_b (
        .i_Clock(clk), .i_Reset(rst_n), .i_SampleReady(ready_b), .i_Sample(samp_b),
        .i_ClearOverflow(1'b0), .o_Overflow(ovf_b), .o_Level(lv_b),
        .o_SPI_CS_n(cs_b), .o_SPI_SCLK(sclk_b), .o_SPI_MOSI(mosi_b)
    );

    // ---------------- frame monitor ----------------
    logic [1:0]  cs_v, sclk_v, mosi_v;
    assign cs_v   = {cs_b, cs_a};
    assign sclk_v = {sclk_b, sclk_a};
    assign mosi_v = {mosi_b, mosi_a};

    logic [15:0] fw    [2][32];
    int          flen  [2][32];
    int          frise [2][32];
    int          gap   [2][32];
    int          fn        [2] = '{0, 0};
    int          low_total [2] = '{0, 0};
    int          edge_err  [2] = '{0, 0};
    int          idle_err  [2] = '{0, 0};
    logic [15:0] acc       [2];
    int          rises     [2];
    int          low       [2];
    int          high      [2];
    logic        prev_cs   [2] = '{1'b1, 1'b1};
    logic        prev_sclk [2] = '{1'b0, 1'b0};
    logic        prev_mosi [2] = '{1'b0, 1'b0};
    logic        have_prev [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                acc[i] = '0; rises[i] = 0; low[i] = 0; high[i] = 0;
                prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; prev_mosi[i] = 1'b0;
                have_prev[i] = 1'b0;
            end else begin
                if (!cs_v[i]) begin
                    if (prev_cs[i]) begin
                        if (have_prev[i] && fn[i] > 0 && fn[i] <= 32) gap[i][fn[i]-1] = high[i];
                        acc[i] = '0; rises[i] = 0; low[i] = 0;
                    end
                    low[i]++;
                    low_total[i]++;
                    if (sclk_v[i] && !prev_sclk[i]) begin
                        acc[i] = {acc[i][14:0], mosi_v[i]};
                        rises[i]++;
                        if (mosi_v[i] !== prev_mosi[i]) edge_err[i]++;
                    end
                end else begin
                    if (!prev_cs[i]) begin
                        if (fn[i] < 32) begin
                            fw[i][fn[i]] = acc[i]; flen[i][fn[i]] = low[i];
                            frise[i][fn[i]] = rises[i];
                        end
                        fn[i]++;
                        have_prev[i] = 1'b1;
                        high[i] = 0;
                    end
                    high[i]++;
                    if (sclk_v[i] || mosi_v[i]) idle_err[i]++;
                end
                prev_cs[i] = cs_v[i]; prev_sclk[i] = sclk_v[i]; prev_mosi[i] = mosi_v[i];
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int d, input int n, input int budget);
        int k = 0;
        while (fn[d] < n && k < budget) begin
            tick();
            k++;
        end
        check("frame_timeout", 32'(fn[d] >= n), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] s    [6] = '{16'h0102, 16'h7F00, 16'hF00F, 16'h0000, 16'hFFFF, 16'h5A5A};
    int          ex_lv[6] = '{1, 2, 2, 3, 4, 4};
    int          ex_ov[6] = '{0, 0, 0, 0, 0, 1};
    int          base;
    int          lowtot;
    int          k;

    initial begin
        // Reset, with a strobe held that must be ignored until release.
        #3 rst_n = 1'b0;
        ready_a = 1'b1; samp_a = 16'h1234;
        tick(); tick();
        check("rst_cs_n",  32'(cs_a),   32'd1);
        check("rst_sclk",  32'(sclk_a), 32'd0);
        check("rst_mosi",  32'(mosi_a), 32'd0);
        check("rst_level", 32'(lv_a),   32'd0);
        check("rst_ovf",   32'(ovf_a),  32'd0);
        rst_n = 1'b1;
        tick();
        ready_a = 1'b0;
        check("first_write_level", 32'(lv_a), 32'd1);

        // 0x1234 -> 0x9234, CS low 129 cycles, 16 rises.
        wait_frames(0, 1, 300);
        check("f1234_word",  32'(fw[0][0]), 32'h9234);
        check("f1234_cslow", 32'(flen[0][0]), 32'd129);
        check("f1234_rises", 32'(frise[0][0]), 32'd16);
        repeat (20) tick();

        // Extremes, back to back with an 8-cycle gap.
        base = fn[0];
        ready_a = 1'b1; samp_a = 16'h8000; tick();
        samp_a = 16'h7FFF; tick();
        ready_a = 1'b0;
        wait_frames(0, base + 2, 400);
        check("fmin_word", 32'(fw[0][base]),   32'h0000);
        check("fmax_word", 32'(fw[0][base+1]), 32'hFFFF);
        check("fext_gap",  32'(gap[0][base]),  32'd8);
        check("fext_period", 32'(flen[0][base] + gap[0][base]), 32'd137);
        repeat (20) tick();

        // Six consecutive strobes into a depth-4 FIFO: s5 dropped.
        base = fn[0];
        for (int i = 0; i < 6; i++) begin
            ready_a = 1'b1; samp_a = s[i];
            tick();
            check("fill_level", 32'(lv_a),  32'(ex_lv[i]));
            check("fill_ovf",   32'(ovf_a), 32'(ex_ov[i]));
        end
        // Clear coinciding with another dropped write: set wins.
        samp_a = 16'h3333; clr_a = 1'b1;
        tick();
        check("ovf_set_wins", 32'(ovf_a), 32'd1);
        check("full_level",   32'(lv_a),  32'd4);
        ready_a = 1'b0;
        tick();
        clr_a = 1'b0;
        check("ovf_cleared", 32'(ovf_a), 32'd0);
        wait_frames(0, base + 5, 1000);
        for (int i = 0; i < 5; i++) check("order_word", 32'(fw[0][base+i]), 32'(s[i] ^ 16'h8000));
        for (int i = 0; i < 4; i++) check("order_gap", 32'(gap[0][base+i]), 32'd8);
        repeat (20) tick();

        // Reset in the middle of bit 7.
        ready_a = 1'b1; samp_a = 16'h0F0F; tick();
        samp_a = 16'h5555; tick();
        ready_a = 1'b0;
        k = 0;
        while (cs_a && k < 50) begin tick(); k++; end
        check("abort_cs_start", 32'(cs_a), 32'd0);
        repeat (57) tick();
        check("abort_pre_level", 32'(lv_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n",  32'(cs_a),   32'd1);
        check("abort_sclk",  32'(sclk_a), 32'd0);
        check("abort_mosi",  32'(mosi_a), 32'd0);
        check("abort_level", 32'(lv_a),   32'd0);
        ready_a = 1'b1; samp_a = 16'h1357;
        tick(); tick();
        check("rst_ignores_strobe", 32'(lv_a), 32'd0);
        ready_a = 1'b0;
        rst_n = 1'b1;
        base = fn[0];
        lowtot = low_total[0];
        repeat (300) tick();
        check("quiet_after_rst", 32'(low_total[0]), 32'(lowtot));
        check("quiet_frames",    32'(fn[0]),        32'(base));
        ready_a = 1'b1; samp_a = 16'hC001; tick();
        ready_a = 1'b0;
        wait_frames(0, base + 1, 300);
        check("post_rst_word",  32'(fw[0][base]),   32'h4001);
        check("post_rst_cslow", 32'(flen[0][base]), 32'd129);

        // CLK_DIV=1: two 0xAAAA samples back to back.
        ready_b = 1'b1; samp_b = 16'hAAAA; tick(); tick();
        ready_b = 1'b0;
        wait_frames(1, 2, 200);
        check("div1_word0",  32'(fw[1][0]),    32'h2AAA);
        check("div1_word1",  32'(fw[1][1]),    32'h2AAA);
        check("div1_rises",  32'(frise[1][0]), 32'd16);
        check("div1_cslow",  32'(flen[1][0]),  32'd33);
        check("div1_period", 32'(flen[1][0] + gap[1][0]), 32'd35);

        check("mosi_on_rise_a", 32'(edge_err[0]), 32'd0);
        check("mosi_on_rise_b", 32'(edge_err[1]), 32'd0);
        check("idle_lines_a",   32'(idle_err[0]), 32'd0);
        check("idle_lines_b",   32'(idle_err[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_spi_output.md
DAC_SPI_OUTPUT -- requirements
Module: dac_spi_output

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, i_Clock cycles per SCLK half-period (legal 1..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, sample buffer entries (power of two, >=2).
REQ-003 SHALL have port i_Clock  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_Reset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_SampleReady  in  1  one-cycle strobe; i_Sample valid.
REQ-006 SHALL have port i_Sample  in  16  signed two's-complement synth sample.
REQ-007 SHALL have port i_ClearOverflow  in  1  clears o_Overflow.
REQ-008 SHALL have port o_Overflow  out  1  sticky: sample dropped on full FIFO.
REQ-009 SHALL have port o_Level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010 SHALL have port o_SPI_CS_n  out  1  DAC chip select, active-low.
REQ-011 SHALL have port o_SPI_SCLK  out  1  SPI clock, mode 0 (idle low).
REQ-012 SHALL have port o_SPI_MOSI  out  1  serial data, MSB first.

Function
REQ-013 SHALL write i_Sample into the FIFO on any cycle with i_SampleReady=1 and FIFO not full.
REQ-014 SHALL drop the sample and set o_Overflow on i_SampleReady=1 with FIFO full and no pop that cycle.
REQ-015 SHALL accept the write when full if a pop occurs the same cycle (level unchanged).
REQ-016 SHALL hold o_Overflow until i_ClearOverflow=1; set wins over clear on the same cycle.
REQ-017 SHALL update o_Level one cycle after each write/pop; simultaneous write+pop leaves it unchanged.
REQ-018 SHALL convert each popped sample to offset binary: word = sample XOR 0x8000.
REQ-019 SHALL implement FSM states IDLE, LOAD, SHIFT, GAP.
REQ-020 IDLE: CS_n=1, SCLK=0, MOSI=0; next state LOAD when o_Level!=0, else IDLE.
REQ-021 LOAD (1 cycle): pop FIFO head, load shift register with converted word, bit counter=0; next SHIFT.
REQ-022 SHALL drive o_SPI_CS_n=0 in LOAD and SHIFT only, and MOSI=shift register bit 15 in LOAD, SHIFT.
REQ-023 SHIFT: each bit = CLK_DIV cycles SCLK=0 then CLK_DIV cycles SCLK=1; at end of high phase SCLK falls and register shifts left by 1.
REQ-024 SHALL leave SHIFT after the 16th high phase (32*CLK_DIV cycles), SCLK=0, to GAP.
REQ-025 GAP: CS_n=1, SCLK=0, MOSI=0 for 2*CLK_DIV cycles; then LOAD if o_Level!=0 else IDLE.
REQ-026 SHALL yield frame period 1+34*CLK_DIV cycles back-to-back (137 at CLK_DIV=4).
REQ-027 SHALL change MOSI only while SCLK is low or on SCLK falling edge, never on rising.
REQ-028 SHALL drive all SPI outputs from registers (no combinational glitches).
REQ-029 SHALL preserve FIFO order; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 SHALL on i_Reset=0 asynchronously force: FSM=IDLE, FIFO empty, o_Level=0, o_Overflow=0, o_SPI_CS_n=1, o_SPI_SCLK=0, o_SPI_MOSI=0, counters=0.
REQ-031 SHALL abort any frame in progress at reset; no partial frame resumes after release.
REQ-032 SHALL ignore i_SampleReady while reset asserted; first write accepted on first rising edge after release.

Verification
REQ-033 Single i_Sample=0x1234 from IDLE (CLK_DIV=4) -> CS_n low 129 cycles, 16 SCLK rises, MOSI captured on rises = 0x9234, then 8-cycle GAP.
REQ-034 i_Sample=-32768 then 32767 -> frames 0x0000 then 0xFFFF, CS_n high exactly 8 cycles between them.
REQ-035 Six strobes s0..s5 on consecutive cycles from IDLE, FIFO_DEPTH=4 -> s0..s4 sent in order, s5 dropped, o_Overflow=1, o_Level peaks at 4.
REQ-036 i_ClearOverflow and a dropped write on the same cycle -> o_Overflow remains 1; clear alone next cycle -> 0.
REQ-037 Reset asserted mid-frame at bit 7 -> CS_n=1, SCLK=0, MOSI=0, o_Level=0 immediately; after release, no SPI activity until new strobe.
REQ-038 CLK_DIV=1 with sample 0xAAAA -> SCLK toggles every cycle, MOSI 0x2AAA, frame period 35 cycles.
